// File: rtl/uart_boot_loader_pkg.sv
// uart_boot_loader_pkg: shared types and constants for the UART boot loader.
package uart_boot_loader_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, CNT0, CNT1, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [7:0] MAGIC_DEF = 8'hA5;
    localparam int CNT_W = 16;

    typedef logic [1:0] lane_t;

endpackage

// File: rtl/boot_word_packer.sv
// boot_word_packer: packs bytes little-endian into 32-bit words and keeps an 8-bit running sum.
module boot_word_packer
    import uart_boot_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        dv_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_vld_o,
    output logic [7:0]  sum_o
);

    lane_t       lane_q;
    logic [23:0] sh_q;
    logic [7:0]  sum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
            sh_q   <= '0;
            sum_q  <= '0;
        end else if (clr_i) begin
            lane_q <= '0;
            sum_q  <= '0;
        end else if (dv_i) begin
            lane_q <= lane_q + 2'd1;
            sum_q  <= sum_q + byte_i;
            sh_q   <= {byte_i, sh_q[23:8]};
        end
    end

    // The 4th byte completes the word combinationally so the top can register it with one cycle latency.
    assign word_o     = {byte_i, sh_q};
    assign word_vld_o = dv_i && lane_q == 2'd3;
    assign sum_o      = sum_q;

endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses a framed UART download into ICCM word writes and holds the
// core in reset until a frame completes with a good checksum.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned MAX_WORDS      = 4096,
    parameter logic [7:0]  MAGIC          = MAGIC_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  prog_i,
    input  logic                  rx_dv_i,
    input  logic [7:0]            rx_byte_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [31:0]           wdata_o,
    output logic                  prog_rst_no,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t                state_q;
    logic                  prog_q, we_q, done_q, err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [CNT_W-1:0]      cnt_q, idx_q;
    logic [TW-1:0]         tmo_q;

    logic             rise, timed, tmo_hit, word_vld;
    logic [31:0]      word;
    logic [7:0]       sum;
    logic [CNT_W-1:0] cnt_full;

    assign rise     = prog_i && !prog_q;
    assign timed    = state_q inside {CNT0, CNT1, DATA, CSUM};
    assign tmo_hit  = timed && !rx_dv_i && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    assign cnt_full = {rx_byte_i, cnt_q[7:0]};

    // Held clear throughout CNT1 so every frame, including ERR retries, starts from lane 0 and sum 0.
    boot_word_packer u_packer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (state_q == CNT1),
        .dv_i       (rx_dv_i && !rise && state_q == DATA),
        .byte_i     (rx_byte_i),
        .word_o     (word),
        .word_vld_o (word_vld),
        .sum_o      (sum)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            prog_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
        end else begin
            prog_q <= prog_i;
            we_q   <= word_vld;
            tmo_q  <= (rx_dv_i || !timed) ? '0 : tmo_q + 1'b1;
            if (word_vld) begin
                addr_q  <= idx_q[ADDR_WIDTH-1:0];
                wdata_q <= word;
                idx_q   <= idx_q + 1'b1;
            end
            if (rise) begin
                state_q <= SYNC;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
            end else if (tmo_hit) begin
                state_q <= ERR;
                err_q   <= 1'b1;
            end else if (rx_dv_i) begin
                case (state_q)
                    SYNC: if (rx_byte_i == MAGIC) state_q <= CNT0;
                    ERR: if (rx_byte_i == MAGIC) begin
                        state_q <= CNT0;
                        err_q   <= 1'b0;
                    end
                    CNT0: begin
                        cnt_q[7:0] <= rx_byte_i;
                        state_q    <= CNT1;
                    end
                    CNT1: begin
                        cnt_q[15:8] <= rx_byte_i;
                        idx_q       <= '0;
                        if (cnt_full == '0 || cnt_full > CNT_W'(MAX_WORDS)) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else state_q <= DATA;
                    end
                    DATA: if (word_vld && idx_q == cnt_q - 16'd1) state_q <= CSUM;
                    CSUM: if (sum + rx_byte_i == 8'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign busy_o      = timed || state_q == SYNC;
    assign prog_rst_no = state_q inside {IDLE, DONE};

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed-vector bench for uart_boot_loader with a reduced timeout.
module tb_uart_boot_loader;

    logic        clk = 1'b0, rst_n = 1'b0, prog = 1'b0, rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        we, prog_rst_n, busy, done, err;
    logic [11:0] addr;
    logic [31:0] wdata;

    int n_cmp = 0, n_bad = 0, n_we = 0, base = 0;
    logic [11:0] wa [64];
    logic [31:0] wd [64];

    always #5 clk = ~clk;

    uart_boot_loader #(.ADDR_WIDTH(12), .MAX_WORDS(4096), .MAGIC(8'hA5), .TIMEOUT_CYCLES(100)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .prog_i      (prog),
        .rx_dv_i     (rx_dv),
        .rx_byte_i   (rx_byte),
        .we_o        (we),
        .addr_o      (addr),
        .wdata_o     (wdata),
        .prog_rst_no (prog_rst_n),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always @(negedge clk) if (we) begin
        if (n_we < 64) begin
            wa[n_we] = addr;
            wd[n_we] = wdata;
        end
        n_we++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic start_dl();
        @(negedge clk);
        prog = 1'b0;
        @(negedge clk);
        prog = 1'b1;
        @(negedge clk);
    endtask

    // Two-word header and payload; the payload bytes sum to 0x4B, so 0xB5 is the good checksum.
    task automatic frame_body();
        logic [7:0] f [11];
        f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        foreach (f[i]) send(f[i]);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_prog_rst", prog_rst_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;

        start_dl();
        chk("t1_rst_low", prog_rst_n, 0);
        chk("t1_busy", busy, 1);
        base = n_we;
        frame_body();
        chk("t1_rst_low_before_csum", prog_rst_n, 0);
        send(8'hB5);
        chk("t1_rst_high", prog_rst_n, 1);
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        chk("t1_busy_idle", busy, 0);
        chk("t1_nwrites", n_we - base, 2);
        chk("t1_addr0", wa[base], 0);
        chk("t1_data0", wd[base], 32'h0000_0013);
        chk("t1_addr1", wa[base+1], 1);
        chk("t1_data1", wd[base+1], 32'hDEAD_BEEF);

        start_dl();
        chk("t2_done_cleared", done, 0);
        base = n_we;
        frame_body();
        send(8'h00);
        chk("t2_nwrites", n_we - base, 2);
        chk("t2_err", err, 1);
        chk("t2_done", done, 0);
        chk("t2_rst_low", prog_rst_n, 0);
        chk("t2_busy_err", busy, 0);
        frame_body();
        chk("t2_retry_busy", busy, 1);
        chk("t2_retry_err_clr", err, 0);
        send(8'hB5);
        chk("t2_retry_done", done, 1);
        chk("t2_retry_rst_high", prog_rst_n, 1);
        chk("t2_retry_nwrites", n_we - base, 4);

        start_dl();
        base = n_we;
        send(8'h55);
        send(8'h12);
        chk("t3_sync_busy", busy, 1);
        chk("t3_sync_nwrites", n_we - base, 0);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hF6);
        chk("t3_nwrites", n_we - base, 1);
        chk("t3_addr", wa[base], 0);
        chk("t3_data", wd[base], 32'h0403_0201);
        chk("t3_done", done, 1);

        start_dl();
        base = n_we;
        send(8'hA5); send(8'h00); send(8'h00);
        chk("t4_zero_err", err, 1);
        chk("t4_zero_rst_low", prog_rst_n, 0);
        start_dl();
        send(8'hA5); send(8'h01); send(8'h10);
        chk("t4_big_err", err, 1);
        chk("t4_nwrites", n_we - base, 0);
        start_dl();
        send(8'hA5); send(8'h00); send(8'h10);
        chk("t4_max_err", err, 0);
        chk("t4_max_busy", busy, 1);

        start_dl();
        base = n_we;
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        repeat (99) @(negedge clk);
        chk("t5_no_early_timeout", err, 0);
        @(negedge clk);
        chk("t5_timeout_err", err, 1);
        chk("t5_busy", busy, 0);
        chk("t5_rst_low", prog_rst_n, 0);
        chk("t5_nwrites", n_we - base, 0);
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        send(8'hF2);
        chk("t5_retry_nwrites", n_we - base, 1);
        chk("t5_retry_data", wd[base], 32'hDDCC_BBAA);
        chk("t5_retry_done", done, 1);

        start_dl();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        @(negedge clk);
        prog = 1'b0;
        @(negedge clk);
        prog    = 1'b1;
        rx_dv   = 1'b1;
        rx_byte = 8'h33;
        @(negedge clk);
        rx_dv = 1'b0;
        chk("t6_done", done, 0);
        chk("t6_err", err, 0);
        chk("t6_busy", busy, 1);
        chk("t6_rst_low", prog_rst_n, 0);
        base = n_we;
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h44); send(8'h55); send(8'h66); send(8'h77);
        send(8'h8A);
        chk("t6_nwrites", n_we - base, 1);
        chk("t6_data", wd[base], 32'h7766_5544);
        chk("t6_done_after", done, 1);

        start_dl();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t7_we", we, 0);
        chk("t7_addr", addr, 0);
        chk("t7_wdata", wdata, 0);
        chk("t7_prog_rst", prog_rst_n, 1);
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_err", err, 0);
        prog = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
